vend_coin_debounce: RTL and testbench
=====================================

// Module: vend_coin_debounce
// PURPOSE
// Receiving end of the divider's tick strobe: consumes the 1-cycle clock-enable pulse and uses it as the
// debounce time base for the vending machine's raw coin buttons. Per input: synchronise, debounce over
// DB_TICKS ticks, detect the press, queue it. Queued presses go one at a time to the vending FSM over a
// valid/ready handshake as one-hot coin events.
// PARAMETERS
// NUM_IN       3   number of coin buttons (bit0 nickel, bit1 dime, bit2 quarter)
// DB_TICKS     4   consecutive ticks an input must differ from its stable level before it flips (>=1)
// SYNC_STAGES  2   flip-flop synchroniser depth per input (>=2)
// PORTS
// clk          in   1        system clock
// reset        in   1        asynchronous, active-low reset (0 = reset)
// tick_en      in   1        1-cycle enable strobe from divider; debounce time base
// btn_raw      in   NUM_IN   asynchronous raw button levels, 1 = pressed
// coin_valid   out  1        coin event presented
// coin_id      out  NUM_IN   one-hot id of presented coin; all-zero when coin_valid=0
// coin_ready   in   1        FSM accepts event; transfer = coin_valid & coin_ready
// btn_stable   out  NUM_IN   debounced level per input
// overrun      out  1        sticky: press lost because same input already pending
// clear_ovr    in   1        synchronous clear of overrun
// BEHAVIOUR
// - Reset (reset=0, async): sync chains, btn_stable, counters, pending, coin_id = 0; coin_valid=0;
//   overrun=0; FSM -> IDLE.
// - Sync: btn_raw passes through SYNC_STAGES flops; sync[i] = last stage. No other use of btn_raw.
// - Debounce per input i, counter cnt[i] of width clog2(DB_TICKS) (min 1):
//   * sync[i]==btn_stable[i]: cnt[i]<=0 every cycle, regardless of tick_en.
//   * sync[i]!=btn_stable[i], tick_en=0: hold.
//   * sync[i]!=btn_stable[i], tick_en=1, cnt[i]<DB_TICKS-1: cnt[i]++.
//   * sync[i]!=btn_stable[i], tick_en=1, cnt[i]==DB_TICKS-1: btn_stable[i]<=sync[i]; cnt[i]<=0.
//   * A bounce back to stable level before the flip zeroes cnt; no partial credit retained.
// - Press: rise[i] = flip cycle with sync[i]=1. Release (1->0) never generates an event.
// - pending[NUM_IN]: rise[i] sets pending[i] next edge. If pending[i] already 1 and not cleared by a
//   transfer this cycle -> overrun<=1, press dropped. Rise and transfer of same i in same cycle ->
//   pending[i] stays 1, no overrun.
// - Output FSM, 2 states:
//   * IDLE: coin_valid=0. If pending!=0: coin_id<=one-hot of lowest set index, coin_valid<=1 -> PRESENT.
//   * PRESENT: coin_valid, coin_id held stable until coin_ready=1. On transfer: clear pending bit of
//     coin_id, coin_valid<=0, coin_id<=0 -> IDLE. Back-to-back events have one idle cycle between them.
//   * coin_ready while IDLE ignored.
// - Latency: btn_raw rise -> btn_stable after SYNC_STAGES cycles + DB_TICKS ticks; coin_valid 2 cycles
//   after btn_stable rises (pending, then PRESENT).
// - overrun: set as above; clear_ovr=1 clears it; set and clear in same cycle -> set wins.
// - Priority fixed lowest index first; no starvation guarantee beyond FSM draining pending.
// TESTING
// T1 reset=0 mid-PRESENT with pending=3'b011 -> all outputs 0 immediately (async); after release, no event.
// T2 DB_TICKS=4, tick_en every 5 clk: btn_raw[1] held high -> btn_stable[1]=1 on 4th tick after sync;
//    coin_valid=1, coin_id=3'b010 2 cycles later; ready=1 -> next cycle coin_valid=0.
// T3 btn_raw[0] high for 3 ticks, low 1 tick, high 4 ticks -> exactly one event, after the final 4 ticks.
// T4 btn_raw[0] and [2] flip same cycle, coin_ready=1 -> events 3'b001 then 3'b100, one idle cycle apart.
// T5 coin_ready=0 while input 2 presented; second debounced press on input 2 -> overrun=1, only one
//    event 3'b100 delivered; clear_ovr=1 -> overrun=0.
// T6 tick_en held 0 with btn_raw toggling -> btn_stable and coin_valid never change; release events never seen.

Source files
------------

// File: rtl/vend_coin_debounce.sv
// Coin button front end for the vending machine.
// Each raw button is synchronised, debounced against the divider's tick strobe,
// turned into a press event on its debounced rising edge, and queued. Queued
// presses are handed to the vending FSM one at a time as one-hot coin events
// over a valid/ready handshake, lowest index first.
module vend_coin_debounce #(
    parameter int NUM_IN      = 3,
    parameter int DB_TICKS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_en,
    input  logic [NUM_IN-1:0] btn_raw,
    output logic              coin_valid,
    output logic [NUM_IN-1:0] coin_id,
    input  logic              coin_ready,
    output logic [NUM_IN-1:0] btn_stable,
    output logic              overrun,
    input  logic              clear_ovr
);

    localparam int CW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

    typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

    logic [NUM_IN-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IN-1:0] sync_s;
    logic [CW-1:0]     cnt_q  [NUM_IN];
    logic [CW-1:0]     cnt_d  [NUM_IN];
    logic [NUM_IN-1:0] stable_q, stable_d;
    logic [NUM_IN-1:0] rise_q, rise_d;
    logic [NUM_IN-1:0] pending_q, pending_d;
    logic              ovr_q, ovr_d;
    logic [NUM_IN-1:0] coin_id_q, coin_id_d;
    state_t            state_q, state_d;
    logic              xfer;
    logic [NUM_IN-1:0] lowest;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign xfer   = coin_valid & coin_ready;
    // Isolate the lowest set pending bit so priority is fixed by index.
    assign lowest = pending_q & (~pending_q + NUM_IN'(1));

    // Synchroniser chain: raw levels are only ever seen through the last stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= btn_raw;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Debounce: a difference must persist for DB_TICKS ticks; any agreement zeroes the count.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_s[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick_en) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync_s[i];
                    cnt_d[i]    = '0;
                    rise_d[i]   = sync_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Press queue and sticky overrun; a transfer frees its slot in the same cycle.
    always_comb begin
        pending_d = pending_q;
        ovr_d     = ovr_q;
        if (clear_ovr) ovr_d = 1'b0;
        if (xfer) pending_d = pending_q & ~coin_id_q;
        for (int i = 0; i < NUM_IN; i++) begin
            if (rise_q[i]) begin
                if (pending_q[i] && !(xfer && coin_id_q[i])) ovr_d = 1'b1;
                pending_d[i] = 1'b1;
            end
        end
    end

    // Debounce, queue and handshake state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
            stable_q  <= '0;
            rise_q    <= '0;
            pending_q <= '0;
            ovr_q     <= 1'b0;
            coin_id_q <= '0;
            state_q   <= IDLE;
        end else begin
            for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= cnt_d[i];
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            pending_q <= pending_d;
            ovr_q     <= ovr_d;
            coin_id_q <= coin_id_d;
            state_q   <= state_d;
        end
    end

    // Handshake FSM next state: pick the lowest pending coin, hold it until accepted.
    always_comb begin
        state_d   = state_q;
        coin_id_d = coin_id_q;
        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    coin_id_d = lowest;
                    state_d   = PRESENT;
                end
            end
            PRESENT: begin
                if (coin_ready) begin
                    coin_id_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                coin_id_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    // Handshake FSM outputs and status.
    always_comb begin
        coin_valid = (state_q == PRESENT);
        coin_id    = coin_id_q;
        btn_stable = stable_q;
        overrun    = ovr_q;
    end

endmodule

// File: tb/tb_vend_coin_debounce.sv
// Directed bench for vend_coin_debounce with default parameters
// (3 inputs, 4 debounce ticks, 2 sync stages); tick_en pulses every 5 clocks.
module tb_vend_coin_debounce;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_en;
    logic [2:0] btn_raw;
    logic       coin_valid;
    logic [2:0] coin_id;
    logic       coin_ready;
    logic [2:0] btn_stable;
    logic       overrun;
    logic       clear_ovr;

    int nerr = 0;
    int nchk = 0;

    vend_coin_debounce #(.NUM_IN(3), .DB_TICKS(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_en    (tick_en),
        .btn_raw    (btn_raw),
        .coin_valid (coin_valid),
        .coin_id    (coin_id),
        .coin_ready (coin_ready),
        .btn_stable (btn_stable),
        .overrun    (overrun),
        .clear_ovr  (clear_ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; returns 1 time unit after the rising edge.
    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic clkn(input int n);
        repeat (n) clk1();
    endtask

    // Five clocks with tick_en high for the last one.
    task automatic tick1();
        tick_en = 1'b0;
        clkn(4);
        tick_en = 1'b1;
        clk1();
        tick_en = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick1();
    endtask

    initial begin
        reset      = 1'b0;
        tick_en    = 1'b0;
        btn_raw    = 3'b000;
        coin_ready = 1'b0;
        clear_ovr  = 1'b0;
        #12;
        chk("rst_valid",   {31'd0, coin_valid}, 32'd0);
        chk("rst_id",      {29'd0, coin_id},    32'd0);
        chk("rst_stable",  {29'd0, btn_stable}, 32'd0);
        chk("rst_overrun", {31'd0, overrun},    32'd0);
        reset = 1'b1;
        clkn(2);

        // T2: single press on input 1
        btn_raw = 3'b010;
        ticks(3);
        chk("t2_stable_3ticks", {29'd0, btn_stable}, 32'd0);
        tick1();
        chk("t2_stable_4ticks", {29'd0, btn_stable}, 32'b010);
        chk("t2_valid_at_flip", {31'd0, coin_valid}, 32'd0);
        clk1();
        chk("t2_valid_pend",    {31'd0, coin_valid}, 32'd0);
        clk1();
        chk("t2_valid",         {31'd0, coin_valid}, 32'd1);
        chk("t2_id",            {29'd0, coin_id},    32'b010);
        coin_ready = 1'b1;
        clk1();
        coin_ready = 1'b0;
        chk("t2_valid_after",   {31'd0, coin_valid}, 32'd0);
        chk("t2_id_after",      {29'd0, coin_id},    32'd0);
        btn_raw = 3'b000;
        ticks(4);
        clkn(3);
        chk("t2_release_stable", {29'd0, btn_stable}, 32'd0);
        chk("t2_release_noevt",  {31'd0, coin_valid}, 32'd0);

        // T3: bounce resets credit on input 0
        btn_raw = 3'b001;
        ticks(3);
        chk("t3_stable_3ticks", {29'd0, btn_stable}, 32'd0);
        btn_raw = 3'b000;
        tick1();
        chk("t3_stable_bounce", {29'd0, btn_stable}, 32'd0);
        btn_raw = 3'b001;
        ticks(3);
        chk("t3_stable_3more",  {29'd0, btn_stable}, 32'd0);
        chk("t3_noevt_early",   {31'd0, coin_valid}, 32'd0);
        tick1();
        chk("t3_stable_final",  {29'd0, btn_stable}, 32'b001);
        clkn(2);
        chk("t3_valid",         {31'd0, coin_valid}, 32'd1);
        chk("t3_id",            {29'd0, coin_id},    32'b001);
        coin_ready = 1'b1;
        clk1();
        coin_ready = 1'b0;
        clkn(3);
        chk("t3_single_evt",    {31'd0, coin_valid}, 32'd0);
        btn_raw = 3'b000;
        ticks(4);
        clk1();

        // T4: inputs 0 and 2 together, ready held high
        btn_raw    = 3'b101;
        coin_ready = 1'b1;
        ticks(4);
        chk("t4_stable", {29'd0, btn_stable}, 32'b101);
        clk1();
        chk("t4_idle_pend", {31'd0, coin_valid}, 32'd0);
        clk1();
        chk("t4_valid1", {31'd0, coin_valid}, 32'd1);
        chk("t4_id1",    {29'd0, coin_id},    32'b001);
        clk1();
        chk("t4_gap",    {31'd0, coin_valid}, 32'd0);
        clk1();
        chk("t4_valid2", {31'd0, coin_valid}, 32'd1);
        chk("t4_id2",    {29'd0, coin_id},    32'b100);
        clk1();
        chk("t4_done",   {31'd0, coin_valid}, 32'd0);
        coin_ready = 1'b0;
        btn_raw    = 3'b000;
        ticks(4);
        clk1();
        chk("t4_released", {29'd0, btn_stable}, 32'd0);

        // T5: second press on input 2 while it is still presented
        btn_raw = 3'b100;
        ticks(4);
        clkn(2);
        chk("t5_valid", {31'd0, coin_valid}, 32'd1);
        chk("t5_id",    {29'd0, coin_id},    32'b100);
        btn_raw = 3'b000;
        ticks(4);
        chk("t5_release_ovr", {31'd0, overrun}, 32'd0);
        btn_raw = 3'b100;
        ticks(4);
        chk("t5_ovr_not_yet", {31'd0, overrun}, 32'd0);
        clk1();
        chk("t5_overrun",     {31'd0, overrun},    32'd1);
        chk("t5_held_id",     {29'd0, coin_id},    32'b100);
        coin_ready = 1'b1;
        clk1();
        coin_ready = 1'b0;
        clkn(4);
        chk("t5_one_evt",     {31'd0, coin_valid}, 32'd0);
        chk("t5_ovr_sticky",  {31'd0, overrun},    32'd1);
        clear_ovr = 1'b1;
        clk1();
        clear_ovr = 1'b0;
        chk("t5_ovr_clear",   {31'd0, overrun},    32'd0);
        btn_raw = 3'b000;
        ticks(4);
        clk1();

        // T6: no ticks, inputs toggling
        tick_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            btn_raw = (k % 2 == 0) ? 3'b111 : 3'b000;
            clkn(7);
        end
        chk("t6_stable", {29'd0, btn_stable}, 32'd0);
        chk("t6_valid",  {31'd0, coin_valid}, 32'd0);
        btn_raw = 3'b000;
        clkn(3);

        // T1: async reset while presenting with two pending
        btn_raw = 3'b011;
        ticks(4);
        clkn(2);
        chk("t1_pre_valid", {31'd0, coin_valid}, 32'd1);
        chk("t1_pre_id",    {29'd0, coin_id},    32'b001);
        btn_raw = 3'b000;
        #2;
        reset = 1'b0;
        #1;
        chk("t1_valid",  {31'd0, coin_valid}, 32'd0);
        chk("t1_id",     {29'd0, coin_id},    32'd0);
        chk("t1_stable", {29'd0, btn_stable}, 32'd0);
        chk("t1_ovr",    {31'd0, overrun},    32'd0);
        clkn(2);
        #3;
        reset = 1'b1;
        ticks(6);
        chk("t1_no_evt", {31'd0, coin_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
